result_drain: RTL and testbench

//  Downstream neighbour of the SIMD datapath's store stage. On a start pulse (driven from datapath
//  out_data_valid), reads LENGTH consecutive PE_COUNT-wide words from result BRAM port B.

---
 rtl/result_drain_if.sv | 48 ++++
 rtl/result_drain.sv | 159 +++++++++++++++
 tb/tb_result_drain.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/result_drain_if.sv
// result_drain_if
//   Groups the result BRAM read port and the AXI4-Stream output of the result
//   drain into one bundle.
//   master : the drain (issues BRAM reads, drives the stream)
//   slave  : the environment (BRAM returning data, stream sink providing ready)
// Signals
//   bram_r_rd_en    BRAM read enable
//   bram_r_rd_addr  BRAM read address
//   bram_r_dout     BRAM read data, valid RD_LATENCY cycles after rd_en
//   m_axis_tdata    stream word, lane 0 in the LSBs
//   m_axis_tvalid   beat valid
//   m_axis_tready   sink ready
//   m_axis_tlast    final beat of a drain
interface result_drain_if #(
    parameter int PE_COUNT   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    localparam int WORD_W = PE_COUNT * DATA_WIDTH;

    logic                  bram_r_rd_en;
    logic [ADDR_WIDTH-1:0] bram_r_rd_addr;
    logic [WORD_W-1:0]     bram_r_dout;
    logic [WORD_W-1:0]     m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        output bram_r_rd_en,
        output bram_r_rd_addr,
        input  bram_r_dout,
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tlast
    );

    modport slave (
        input  bram_r_rd_en,
        input  bram_r_rd_addr,
        output bram_r_dout,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tlast
    );
endinterface

// File: rtl/result_drain.sv
// result_drain
//   Drains LENGTH consecutive PE_COUNT-wide result words from the result BRAM
//   and streams them out as an AXI4-Stream master, one word per beat. Reads
//   go through a fixed-latency BRAM pipeline into a small output FIFO; reads
//   are only issued while the FIFO has room for everything already in flight,
//   so returning data can always be accepted.
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   start          1-cycle pulse, begins a drain (ignored unless idle)
//   base_addr      first BRAM address, sampled on an accepted start
//   length         number of words (0..2^ADDR_WIDTH), sampled on an accepted start
//   busy           high from the cycle after an accepted start until done
//   done           1-cycle pulse once the last beat has been handshaken
//   stall_cycles   cycles with tvalid & !tready since the last accepted start
//   bus            result_drain_if master: BRAM read port + AXIS output
// Build option
//   RESULT_DRAIN_STALL_CNT_EN : builds the saturating stall counter; without
//   it stall_cycles is tied to zero.
module result_drain #(
    parameter int PE_COUNT   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           stall_cycles,
    result_drain_if.master        bus
);
    localparam int WORD_W = PE_COUNT * DATA_WIDTH;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;
    localparam logic [PTR_W:0]      PTR_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   len_q, issued_q, popped_q;
    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [WORD_W-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr_q, rd_ptr_q, fifo_count;
    logic [31:0]           inflight;
    logic                  start_acc, credit_ok, rd_en, push, pop, tvalid, last_beat;

    always_comb begin
        start_acc  = (state_q == S_IDLE) && start;
        fifo_count = wr_ptr_q - rd_ptr_q;
        inflight   = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + 32'(vld_q[i]);
        end
        // Reserve a FIFO slot for every read still in the BRAM pipe, so a
        // returning word always has somewhere to go.
        credit_ok = (32'(fifo_count) + inflight) < 32'(FIFO_DEPTH);
        rd_en     = (state_q == S_RUN) && (issued_q < len_q) && credit_ok;
        push      = vld_q[RD_LATENCY-1];
        tvalid    = (fifo_count != '0);
        pop       = tvalid && bus.m_axis_tready;
        // FIFO is in order, so the head is always beat number popped_q.
        last_beat = (popped_q == (len_q - CNT_ONE));
    end

    // Read-valid shift pipe: bit k set means a read issued k+1 cycles ago.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = rd_en;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    assign bus.bram_r_rd_en   = rd_en;
    assign bus.bram_r_rd_addr = base_q + issued_q[ADDR_WIDTH-1:0];
    assign bus.m_axis_tvalid  = tvalid;
    assign bus.m_axis_tdata   = fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign bus.m_axis_tlast   = tvalid && last_beat;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = (length != '0) ? S_RUN : S_FINISH;
            S_RUN:    if (pop && last_beat) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_FINISH);
    end

    // Drain bookkeeping, read pipe and FIFO pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            popped_q <= '0;
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            vld_q <= vld_d;
            if (start_acc) begin
                base_q   <= base_addr;
                len_q    <= length;
                issued_q <= '0;
                popped_q <= '0;
            end else begin
                if (rd_en) issued_q <= issued_q + CNT_ONE;
                if (pop)   popped_q <= popped_q + CNT_ONE;
            end
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // FIFO storage (data only, no reset)
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= bus.bram_r_dout;
    end

`ifdef RESULT_DRAIN_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if (tvalid && !bus.m_axis_tready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_result_drain.sv
module tb_result_drain;
    localparam int PE = 4;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int RL = 2;
    localparam int FD = 4;
    localparam int WW = PE * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [31:0]   stall_cycles;

    result_drain_if #(.PE_COUNT(PE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    result_drain #(
        .PE_COUNT(PE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .RD_LATENCY(RL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .stall_cycles(stall_cycles), .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WW-1:0] word(input logic [AW-1:0] a);
        logic [WW-1:0] w;
        for (int k = 0; k < PE; k++) w[k*DW +: DW] = 32'hA500_0000 | (32'(a) << 8) | 32'(k);
        return w;
    endfunction

    // BRAM model: data for the address presented RL cycles earlier
    logic [AW-1:0] a_p0, a_p1;
    always @(posedge clk) begin
        a_p0 <= bus.bram_r_rd_addr;
        a_p1 <= a_p0;
    end
    assign bus.bram_r_dout = word(a_p1);

    task automatic chk_i(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_w(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // scoreboard
    logic [WW-1:0] exp_data_q [$];
    logic [AW-1:0] exp_addr_q [$];
    logic          exp_last_q [$];

    int beats, first_cyc, last_cyc, done_cyc, done_cnt, stall_tb, occ, start_cyc;
    logic [1:0]    tb_vld;
    logic          prev_stall;
    logic [WW-1:0] prev_data;
    logic          prev_last;

    always @(posedge clk) begin
        if (rst) tb_vld <= '0;
        else     tb_vld <= {tb_vld[0], bus.bram_r_rd_en};
    end

    always @(negedge clk) begin
        if (rst) begin
            occ        = 0;
            prev_stall = 1'b0;
        end else begin
            chk_i("tvalid_vs_model", int'(bus.m_axis_tvalid), int'(occ != 0));
            if (prev_stall) begin
                chk_i("stall_tvalid_hold", int'(bus.m_axis_tvalid), 1);
                chk_w("stall_tdata_hold", bus.m_axis_tdata, prev_data);
                chk_i("stall_tlast_hold", int'(bus.m_axis_tlast), int'(prev_last));
            end
            if (bus.bram_r_rd_en) begin
                if (exp_addr_q.size() == 0) chk_i("unexpected_read_addr", int'(bus.bram_r_rd_addr), -1);
                else chk_i("read_addr", int'(bus.bram_r_rd_addr), int'(exp_addr_q.pop_front()));
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                beats++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (exp_data_q.size() == 0) begin
                    chk_w("unexpected_beat", bus.m_axis_tdata, '0);
                    chk_i("unexpected_beat_count", beats, 0);
                end else begin
                    chk_w("beat_data", bus.m_axis_tdata, exp_data_q.pop_front());
                    chk_i("beat_tlast", int'(bus.m_axis_tlast), int'(exp_last_q.pop_front()));
                end
            end
            if (bus.m_axis_tvalid && !bus.m_axis_tready) stall_tb++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            occ = occ + int'(tb_vld[1]) - int'(bus.m_axis_tvalid && bus.m_axis_tready);
            chk_i("fifo_occ_le_depth", int'(occ > FD), 0);
            prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
            prev_data  = bus.m_axis_tdata;
            prev_last  = bus.m_axis_tlast;
        end
    end

    function automatic logic ready_for(input int mode, input int k);
        if (mode == 0) return 1'b1;
        return ((k % 4) == 0) || ((k % 4) == 3);
    endfunction

    task automatic push_expect(input logic [AW-1:0] b, input logic [AW:0] n);
        logic [AW-1:0] a;
        for (int i = 0; i < int'(n); i++) begin
            a = b + AW'(i);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(word(a));
            exp_last_q.push_back(i == int'(n) - 1);
        end
    endtask

    task automatic flush_expect();
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_last_q.delete();
    endtask

    // One drain. bogus_k >= 0 pulses an extra start that many cycles in.
    task automatic run_vec(input logic [AW-1:0] b, input logic [AW:0] n, input int mode,
                           input int exp_done_rel, input int bogus_k);
        push_expect(b, n);
        beats = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0; stall_tb = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; length = n; start_cyc = cyc;
        bus.m_axis_tready = ready_for(mode, 0);
        chk_i("busy_before_accept", int'(busy), 0);
        for (int k = 1; k < 400 && done_cyc < 0; k++) begin
            @(posedge clk); #1;
            if (k == bogus_k) begin
                start = 1'b1; base_addr = 10'h200; length = 11'd3;
            end else begin
                start = 1'b0;
            end
            bus.m_axis_tready = ready_for(mode, k);
            if (k == 1) chk_i("busy_after_accept", int'(busy), 1);
        end
        chk_i("done_seen", int'(done_cyc >= 0), 1);
        chk_i("busy_after_done", int'(busy), 0);
        @(negedge clk);
        chk_i("beat_count", beats, int'(n));
        chk_i("scoreboard_empty", exp_data_q.size() + exp_addr_q.size(), 0);
        chk_i("done_pulses", done_cnt, 1);
        if (exp_done_rel >= 0) chk_i("done_latency", done_cyc - start_cyc, exp_done_rel);
        if (mode == 0 && n != 0) begin
            chk_i("first_beat_latency", first_cyc - start_cyc, RL + 2);
            chk_i("no_bubbles", last_cyc - first_cyc, int'(n) - 1);
        end
`ifdef RESULT_DRAIN_STALL_CNT_EN
        chk_i("stall_cycles", int'(stall_cycles), stall_tb);
`else
        chk_i("stall_cycles", int'(stall_cycles), 0);
`endif
        flush_expect();
    endtask

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   len;
        int            mode;          // 0: tready=1, 1: tready 1-0-0-1
        int            exp_done_rel;  // done cycle relative to start, -1 = not checked
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{base: 10'h010, len: 11'd8,  mode: 0, exp_done_rel: 12};
        vecs[1] = '{base: 10'h3FE, len: 11'd4,  mode: 0, exp_done_rel: 8};
        vecs[2] = '{base: 10'h020, len: 11'd16, mode: 1, exp_done_rel: -1};
        vecs[3] = '{base: 10'h000, len: 11'd0,  mode: 0, exp_done_rel: 1};
        vecs[4] = '{base: 10'h3F0, len: 11'd1,  mode: 0, exp_done_rel: 5};
        vecs[5] = '{base: 10'h100, len: 11'd12, mode: 1, exp_done_rel: -1};

        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; bus.m_axis_tready = 1'b0;
        beats = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0; stall_tb = 0;
        occ = 0; start_cyc = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_i("rst_busy", int'(busy), 0);
        chk_i("rst_done", int'(done), 0);
        chk_i("rst_rd_en", int'(bus.bram_r_rd_en), 0);
        chk_i("rst_rd_addr", int'(bus.bram_r_rd_addr), 0);
        chk_i("rst_tvalid", int'(bus.m_axis_tvalid), 0);
        chk_i("rst_tlast", int'(bus.m_axis_tlast), 0);
        chk_i("rst_stall_cycles", int'(stall_cycles), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run_vec(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].exp_done_rel, -1);
        end

        // start while busy is ignored
        run_vec(10'h180, 11'd4, 0, 8, 2);

        // reset in the middle of a drain after 3 beats
        push_expect(10'h050, 11'd16);
        beats = 0; first_cyc = -1; done_cyc = -1; done_cnt = 0; stall_tb = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'h050; length = 11'd16; start_cyc = cyc;
        bus.m_axis_tready = 1'b1;
        for (int k = 1; k < 100 && beats < 3; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk_i("mid_reset_beats", beats, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_i("mid_rst_busy", int'(busy), 0);
        chk_i("mid_rst_done", int'(done), 0);
        chk_i("mid_rst_rd_en", int'(bus.bram_r_rd_en), 0);
        chk_i("mid_rst_rd_addr", int'(bus.bram_r_rd_addr), 0);
        chk_i("mid_rst_tvalid", int'(bus.m_axis_tvalid), 0);
        chk_i("mid_rst_tlast", int'(bus.m_axis_tlast), 0);
        chk_i("mid_rst_stall_cycles", int'(stall_cycles), 0);
        flush_expect();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        chk_i("post_rst_no_beats", beats, 3);
        run_vec(10'h123, 11'd5, 0, 9, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
